// File: rtl/ccc_cfg_pkg.sv
// rtl/ccc_cfg_pkg.sv - shared types and CCC config word layout for the dynamic-config sequencer
package ccc_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_UPDATE,
        ST_WAIT_LOCK,
        ST_RUN
    } ccc_state_e;

    localparam int CCC_CFG_WIDTH = 81;

    // Declared MSB first, so findiv lands at bits [6:0], fbdiv at [13:7], and so on upward.
    typedef struct packed {
        logic [16:0] reserved;
        logic [2:0]  vcosel;
        logic [4:0]  dlyglc;
        logic [4:0]  dlyglb;
        logic [4:0]  dlygla;
        logic [2:0]  ocmux;
        logic [4:0]  ocdiv;
        logic [2:0]  obmux;
        logic [4:0]  obdiv;
        logic [2:0]  oamux;
        logic [4:0]  oadiv;
        logic        xdlysel;
        logic [1:0]  fbsel;
        logic [4:0]  fbdly;
        logic [6:0]  fbdiv;
        logic [6:0]  findiv;
    } ccc_cfg_t;

    // Power-up config: all outputs driven straight from the RCOSC reference with the PLL bypassed.
    localparam ccc_cfg_t CCC_CFG_RCOSC_DEFAULT = '{
        reserved: 17'h0,
        vcosel:   3'd0,
        dlyglc:   5'd0,
        dlyglb:   5'd0,
        dlygla:   5'd0,
        ocmux:    3'd1,
        ocdiv:    5'd0,
        obmux:    3'd1,
        obdiv:    5'd0,
        oamux:    3'd1,
        oadiv:    5'd0,
        xdlysel:  1'b0,
        fbsel:    2'b01,
        fbdly:    5'd0,
        fbdiv:    7'd0,
        findiv:   7'd0
    };

endpackage

// File: rtl/ccc_lock_filter.sv
// rtl/ccc_lock_filter.sv - synchronizes raw PLL LOCK and qualifies it over a run of stable cycles
module ccc_lock_filter #(
    parameter int LOCK_STABLE = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic pll_lock,
    output logic lock_s,
    output logic stable,
    output logic fell
);

    localparam int CNT_W = $clog2(LOCK_STABLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_STABLE - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             prev_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= pll_lock;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (!sync2_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // cnt_q holds the number of earlier high cycles, so stable marks the LOCK_STABLE-th one.
    assign lock_s = sync2_q;
    assign stable = sync2_q && (cnt_q == CNT_LAST);
    assign fell   = prev_q && !sync2_q;

endmodule

// File: rtl/ccc_dynconfig_ctrl.sv
// rtl/ccc_dynconfig_ctrl.sv - run-time CCC/PLL reconfiguration sequencer over the serial dynamic-config port
module ccc_dynconfig_ctrl
    import ccc_cfg_pkg::*;
#(
    parameter int CFG_WIDTH    = 81,
    parameter int SCLK_DIV     = 2,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                 FAB_CLK,
    input  logic                 FAB_RESET_N,
    input  logic                 CFG_REQ,
    input  logic [CFG_WIDTH-1:0] CFG_DATA,
    output logic                 CFG_ACK,
    output logic                 CFG_DONE,
    output logic                 CFG_ERR,
    output logic                 BUSY,
    output logic                 LOCKED,
    output logic                 LOL,
    input  logic                 PLL_LOCK,
    output logic                 MODE,
    output logic                 SCLK,
    output logic                 SDIN,
    output logic                 SSHIFT,
    output logic                 SUPDATE
);

    localparam int BIT_W = $clog2(CFG_WIDTH + 1);
    localparam int DIV_W = $clog2(2 * SCLK_DIV + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(CFG_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] PHASE_LAST = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(LOCK_TIMEOUT - 1);

    ccc_state_e           state_q;
    ccc_state_e           state_d;
    logic [CFG_WIDTH-1:0] shadow_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DIV_W-1:0]     div_q;
    logic [TO_W-1:0]      to_q;
    logic                 sclk_q;
    logic                 ack_q;
    logic                 done_q;
    logic                 err_q;
    logic                 locked_q;
    logic                 lol_q;

    logic lock_s;
    logic stable;
    logic fell;
    logic accept;
    logic sclk_fall;
    logic phase_end;
    logic lock_ok;
    logic lock_to;

    ccc_lock_filter #(
        .LOCK_STABLE(LOCK_STABLE)
    ) u_lock_filter (
        .clk     (FAB_CLK),
        .resetn  (FAB_RESET_N),
        .pll_lock(PLL_LOCK),
        .lock_s  (lock_s),
        .stable  (stable),
        .fell    (fell)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        sclk_fall = 1'b0;
        phase_end = (div_q == PHASE_LAST);
        lock_ok   = 1'b0;
        lock_to   = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                accept = CFG_REQ;
                if (CFG_REQ) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                sclk_fall = sclk_q && (div_q == DIV_LAST);
                if (sclk_fall && (bit_q == BIT_LAST)) state_d = ST_GAP;
            end
            ST_GAP: begin
                if (phase_end) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (phase_end) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // A lock qualifying on the final timeout cycle still counts as success.
                lock_ok = stable;
                lock_to = !stable && (to_q == TO_LAST);
                if (lock_ok) state_d = ST_RUN;
                else if (lock_to) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!FAB_RESET_N) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            to_q     <= '0;
            sclk_q   <= 1'b0;
            ack_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            lol_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= accept;
            done_q  <= lock_ok || lock_to;

            if (accept) begin
                shadow_q <= CFG_DATA;
            end else if (sclk_fall) begin
                shadow_q <= shadow_q >> 1;
            end

            if (accept) begin
                bit_q <= '0;
            end else if (sclk_fall && (bit_q != BIT_LAST)) begin
                bit_q <= bit_q + BIT_W'(1);
            end

            // One counter paces SCLK half-periods in SHIFT and the GAP/UPDATE windows.
            if ((state_d != state_q) || ((state_q == ST_SHIFT) && (div_q == DIV_LAST))) begin
                div_q <= '0;
            end else if (state_q inside {ST_SHIFT, ST_GAP, ST_UPDATE}) begin
                div_q <= div_q + DIV_W'(1);
            end

            if (state_q != ST_SHIFT) begin
                sclk_q <= 1'b0;
            end else if (div_q == DIV_LAST) begin
                sclk_q <= !sclk_q;
            end

            if (state_q != ST_WAIT_LOCK) begin
                to_q <= '0;
            end else if (to_q != TO_LAST) begin
                to_q <= to_q + TO_W'(1);
            end

            if (accept) begin
                err_q    <= 1'b0;
                lol_q    <= 1'b0;
                locked_q <= 1'b0;
            end else if (lock_ok) begin
                locked_q <= 1'b1;
            end else if (lock_to) begin
                err_q <= 1'b1;
            end else if (state_q == ST_RUN) begin
                if (!lock_s) locked_q <= 1'b0;
                else if (stable) locked_q <= 1'b1;
                if (fell) lol_q <= 1'b1;
            end
        end
    end

    assign BUSY     = state_q inside {ST_SHIFT, ST_GAP, ST_UPDATE, ST_WAIT_LOCK};
    assign MODE     = BUSY;
    assign CFG_ACK  = ack_q;
    assign CFG_DONE = done_q;
    assign CFG_ERR  = err_q;
    assign LOCKED   = locked_q;
    assign LOL      = lol_q;
    assign SCLK     = sclk_q;
    assign SDIN     = (state_q == ST_SHIFT) && shadow_q[0];
    assign SSHIFT   = (state_q == ST_SHIFT);
    assign SUPDATE  = (state_q == ST_UPDATE);

endmodule

// File: tb/tb_ccc_dynconfig_ctrl.sv
// tb/tb_ccc_dynconfig_ctrl.sv - scoreboard bench for ccc_dynconfig_ctrl with a serial CCC model
module tb_ccc_dynconfig_ctrl;
    import ccc_cfg_pkg::*;

    localparam int W = 81;
    localparam int K_ACK  = 0;
    localparam int K_UPD  = 1;
    localparam int K_DONE = 2;

    logic         FAB_CLK = 1'b0;
    logic         FAB_RESET_N;
    logic         CFG_REQ;
    logic [W-1:0] CFG_DATA;
    logic         PLL_LOCK;
    logic         CFG_ACK, CFG_DONE, CFG_ERR, BUSY, LOCKED, LOL;
    logic         MODE, SCLK, SDIN, SSHIFT, SUPDATE;

    ccc_dynconfig_ctrl #(
        .CFG_WIDTH   (W),
        .SCLK_DIV    (2),
        .LOCK_STABLE (4),
        .LOCK_TIMEOUT(1000)
    ) dut (
        .FAB_CLK    (FAB_CLK),
        .FAB_RESET_N(FAB_RESET_N),
        .CFG_REQ    (CFG_REQ),
        .CFG_DATA   (CFG_DATA),
        .CFG_ACK    (CFG_ACK),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR),
        .BUSY       (BUSY),
        .LOCKED     (LOCKED),
        .LOL        (LOL),
        .PLL_LOCK   (PLL_LOCK),
        .MODE       (MODE),
        .SCLK       (SCLK),
        .SDIN       (SDIN),
        .SSHIFT     (SSHIFT),
        .SUPDATE    (SUPDATE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int cyc = 0;
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_w(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    typedef struct {
        int           kind;
        int           cyc;
        logic [W-1:0] word;
        logic         err;
        logic         locked;
        logic         lol;
    } exp_t;

    exp_t exp_q[$];

    task automatic push(input int kind, input int c, input logic [W-1:0] w,
                        input logic e, input logic l, input logic o);
        exp_t x;
        x.kind   = kind;
        x.cyc    = c;
        x.word   = w;
        x.err    = e;
        x.locked = l;
        x.lol    = o;
        exp_q.push_back(x);
    endtask

    task automatic pop_exp(input int kind, output bit ok, output exp_t e);
        ok = 1'b0;
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            ok = (e.kind == kind);
        end
    endtask

    // CCC serial model: samples SDIN on every SCLK rise, LSB first.
    logic [W-1:0] m_word;
    int           m_rises;
    always @(posedge SCLK or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            m_word  <= '0;
            m_rises <= 0;
        end else begin
            m_word  <= {SDIN, m_word[W-1:1]};
            m_rises <= m_rises + 1;
        end
    end

    int   sh_cnt    = 0;
    int   up_cnt    = 0;
    int   rise_base = 0;
    logic up_prev   = 1'b0;

    always @(negedge FAB_CLK) begin
        exp_t e;
        bit   ok;
        if (!FAB_RESET_N) begin
            sh_cnt    = 0;
            up_cnt    = 0;
            rise_base = 0;
            up_prev   = 1'b0;
        end else begin
            if (SSHIFT) sh_cnt++;
            if (CFG_ACK) begin
                pop_exp(K_ACK, ok, e);
                if (ok) begin
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_err_cleared", int'(CFG_ERR), 0);
                    chk("ack_lol_cleared", int'(LOL), 0);
                    chk("ack_locked_cleared", int'(LOCKED), 0);
                    chk("ack_mode", int'(MODE), 1);
                    chk("ack_busy", int'(BUSY), 1);
                end
            end
            if (SUPDATE && !up_prev) begin
                pop_exp(K_UPD, ok, e);
                if (ok) begin
                    chk("update_cycle", cyc, e.cyc);
                    chk_w("model_word", m_word, e.word);
                    chk("sclk_rises", m_rises - rise_base, 81);
                    chk("shift_cycles", sh_cnt, 324);
                end
                rise_base = m_rises;
                sh_cnt    = 0;
            end
            if (SUPDATE) begin
                up_cnt++;
            end else if (up_prev) begin
                chk("supdate_len", up_cnt, 4);
                up_cnt = 0;
            end
            if (CFG_DONE) begin
                pop_exp(K_DONE, ok, e);
                if (ok) begin
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_err", int'(CFG_ERR), int'(e.err));
                    chk("done_locked", int'(LOCKED), int'(e.locked));
                    chk("done_lol", int'(LOL), int'(e.lol));
                    chk("done_mode", int'(MODE), 0);
                    chk("done_busy", int'(BUSY), 0);
                end
            end
            up_prev = SUPDATE;
        end
    end

    task automatic at_cycle(input int n);
        while (cyc < n) @(negedge FAB_CLK);
    endtask

    // Called at a negedge; ACK lands one cycle later, SUPDATE rises 1+324+4 cycles later.
    task automatic do_req(input logic [W-1:0] w, output int c);
        c        = cyc;
        CFG_REQ  = 1'b1;
        CFG_DATA = w;
        push(K_ACK, c + 1, '0, 1'b0, 1'b0, 1'b0);
        push(K_UPD, c + 329, w, 1'b0, 1'b0, 1'b0);
        @(negedge FAB_CLK);
        CFG_REQ  = 1'b0;
        CFG_DATA = '0;
    endtask

    function automatic int out_vec();
        return int'({CFG_ACK, CFG_DONE, CFG_ERR, BUSY, LOCKED, LOL,
                     MODE, SCLK, SDIN, SSHIFT, SUPDATE});
    endfunction

    initial begin
        int           c;
        int           l;
        int           d;
        logic [W-1:0] w_dflt;
        w_dflt      = CCC_CFG_RCOSC_DEFAULT;
        FAB_RESET_N = 1'b0;
        CFG_REQ     = 1'b0;
        CFG_DATA    = '0;
        PLL_LOCK    = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        chk("reset_outputs", out_vec(), 0);
        FAB_RESET_N = 1'b1;
        @(negedge FAB_CLK);
        chk("idle_busy", int'(BUSY), 0);

        // Reset while bit 40 is on the wire aborts the shift.
        do_req(w_dflt, c);
        at_cycle(c + 163);
        chk("mid_shift_sshift", int'(SSHIFT), 1);
        FAB_RESET_N = 1'b0;
        exp_q.delete();
        @(negedge FAB_CLK);
        chk("reset_mid_shift_outputs", out_vec(), 0);
        @(negedge FAB_CLK);
        FAB_RESET_N = 1'b1;
        @(negedge FAB_CLK);

        // Full reshift of a new word, then lock 50 cycles after SUPDATE.
        do_req(81'h1_2345_6789_ABCD_EF01_2345, c);
        at_cycle(c + 379);
        PLL_LOCK = 1'b1;
        push(K_DONE, c + 385, '0, 1'b0, 1'b1, 1'b0);
        at_cycle(c + 387);
        chk("run_locked", int'(LOCKED), 1);
        chk("run_mode", int'(MODE), 0);

        // Accept from RUN, lock never returns: timeout 1000 cycles into WAIT_LOCK.
        do_req(81'h0_DEAD_BEEF_0123_4567_89AB, c);
        PLL_LOCK = 1'b0;
        push(K_DONE, c + 1333, '0, 1'b1, 1'b0, 1'b0);
        at_cycle(c + 1336);
        chk("timeout_err_sticky", int'(CFG_ERR), 1);
        chk("timeout_locked", int'(LOCKED), 0);
        chk("timeout_busy", int'(BUSY), 0);

        // Glitchy lock: 3 high, 1 low, then held; only the final run qualifies.
        do_req(81'h1_FFFF_0000_FFFF_0000_8001, c);
        at_cycle(c + 340);
        l        = cyc;
        PLL_LOCK = 1'b1;
        push(K_DONE, l + 10, '0, 1'b0, 1'b1, 1'b0);
        at_cycle(l + 3);
        PLL_LOCK = 1'b0;
        at_cycle(l + 4);
        PLL_LOCK = 1'b1;
        at_cycle(l + 20);
        d        = cyc;
        PLL_LOCK = 1'b0;
        at_cycle(d + 1);
        PLL_LOCK = 1'b1;
        at_cycle(d + 2);
        chk("lol_pre_locked", int'(LOCKED), 1);
        chk("lol_pre_lol", int'(LOL), 0);
        at_cycle(d + 3);
        chk("lol_drop_locked", int'(LOCKED), 0);
        chk("lol_set", int'(LOL), 1);
        at_cycle(d + 6);
        chk("relock_not_yet", int'(LOCKED), 0);
        at_cycle(d + 7);
        chk("relock_locked", int'(LOCKED), 1);
        chk("relock_lol_sticky", int'(LOL), 1);

        // REQ held through a whole busy sequence with a second word behind it.
        c        = cyc;
        CFG_REQ  = 1'b1;
        CFG_DATA = 81'h0_5555_AAAA_5555_AAAA_5555;
        push(K_ACK, c + 1, '0, 1'b0, 1'b0, 1'b0);
        push(K_UPD, c + 329, 81'h0_5555_AAAA_5555_AAAA_5555, 1'b0, 1'b0, 1'b0);
        push(K_DONE, c + 1333, '0, 1'b1, 1'b0, 1'b0);
        push(K_ACK, c + 1334, '0, 1'b0, 1'b0, 1'b0);
        push(K_UPD, c + 1662, 81'h1_0000_0000_0000_0000_0001, 1'b0, 1'b0, 1'b0);
        @(negedge FAB_CLK);
        CFG_DATA = 81'h1_0000_0000_0000_0000_0001;
        PLL_LOCK = 1'b0;
        at_cycle(c + 600);
        chk("held_req_busy", int'(BUSY), 1);
        at_cycle(c + 1334);
        CFG_REQ = 1'b0;
        at_cycle(c + 1672);
        l        = cyc;
        PLL_LOCK = 1'b1;
        push(K_DONE, l + 6, '0, 1'b0, 1'b1, 1'b0);
        at_cycle(l + 8);
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
